spi_cmd_rx: RTL and testbench
=============================

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 The block SHALL have the port sclk, input, 1 bit: SPI clock from the host MCU, asynchronous to clk, at most clk/8.
REQ-004 The block SHALL have the port cs_n, input, 1 bit: SPI chip select, active low, asynchronous.
REQ-005 The block SHALL have the port mosi, input, 1 bit: SPI data in, MSB first, SPI mode 0.
REQ-006 The block SHALL have the port miso, output, 1 bit: SPI data out, for readback only.
REQ-007 The block SHALL have the port selector, output, 4 bits: waveform select fed to the wavegen top.
REQ-008 The block SHALL have the port freq_step, output, 12 bits: phase-accumulator increment for the wavegen.
REQ-009 The block SHALL have the port run, output, 1 bit: wavegen enable.
REQ-010 The block SHALL have the port cfg_strobe, output, 1 bit: one-cycle pulse when a valid frame commits.
REQ-011 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-012 The block SHALL pass sclk, cs_n and mosi through 2-flop synchronizers, then a third flop for edge detection.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-014 IDLE SHALL go to SHIFT only on a detected cs_n falling edge; the bit counter SHALL clear to 0 on that transition.
REQ-015 In SHIFT, each detected sclk rising edge SHALL shift synchronized mosi into a 16-bit shift register LSB-side and increment a 5-bit bit counter, saturating at 31.
REQ-016 In SHIFT, a detected cs_n rising edge SHALL go to COMMIT when the bit count is exactly 16, and otherwise to IDLE with frame_err pulsed for one cycle.
REQ-017 The frame SHALL be opcode[15:12] and data[11:0].
REQ-018 Opcode 0x1 SHALL set selector = data[3:0].
REQ-019 Opcode 0x2 SHALL set freq_step = data[11:0].
REQ-020 Opcode 0x3 SHALL set run = data[0].
REQ-021 Opcode 0x0 SHALL be a NOP.
REQ-022 Opcodes 0x4-0xF SHALL leave all registers unchanged and pulse frame_err.
REQ-023 COMMIT SHALL last one cycle, update the addressed register, pulse cfg_strobe for valid opcodes 0x0-0x3, and return to IDLE.
REQ-024 Commit latency: new output values and cfg_strobe SHALL appear on the 4th rising clk edge after cs_n rises at the pin (2 sync + 1 detect + 1 commit).
REQ-025 cfg_strobe and frame_err SHALL never assert in the same cycle.
REQ-026 Outputs SHALL be registered and SHALL change only in COMMIT or on reset.
REQ-027 sclk edges detected while in IDLE SHALL be ignored.
REQ-028 A cs_n fall and rise inside the synchronizer window with no sclk SHALL be treated as a 0-bit frame, giving frame_err.

Reset
REQ-029 While rst is high, the block SHALL hold: FSM IDLE, selector 4'b0100 (sine), freq_step 12'd1, run 0, cfg_strobe 0, frame_err 0, miso 0, counter and shift register 0.
REQ-030 A reset mid-frame SHALL discard the partial frame with no strobe or error pulse.
REQ-031 If cs_n is low when rst deasserts, the block SHALL wait for a cs_n high then low sequence before accepting bits.

Configuration
REQ-032 With SPI_READBACK_EN defined, on a cs_n fall the block SHALL load the status word {selector, freq_step}.
REQ-033 With SPI_READBACK_EN defined, miso SHALL present the status MSB within 1 clk of cs_n fall detection and shift on each detected sclk falling edge.
REQ-034 With SPI_READBACK_EN defined, miso SHALL be 0 whenever synchronized cs_n is high.
REQ-035 Without SPI_READBACK_EN, miso SHALL be tied to constant 0 and no readback logic SHALL be synthesized.

Verification
REQ-036 Frame 0x1003 at sclk = clk/8: selector = 4'b0011 and one cfg_strobe, both on the 4th clk edge after cs_n rises.
REQ-037 Frame 0x2ABC, then frame 0x3001: freq_step = 12'hABC, then run = 1; selector stays at its reset value 4'b0100.
REQ-038 A 15-bit frame and a 17-bit frame: frame_err pulses once each; cfg_strobe never pulses; outputs unchanged.
REQ-039 Frame 0x7123: frame_err pulses; no register changes.
REQ-040 rst asserted after 8 bits of frame 0x2FFF, released with cs_n still low, then 8 more bits and cs_n high: no strobe, no error, freq_step = 1.
REQ-041 With SPI_READBACK_EN, after committing 0x1005 and 0x2123, a NOP frame 0x0000 returns 0x5123 on miso MSB first.

Source files
------------

// File: rtl/spi_cmd_rx_if.sv
// SPI bus bundle between the host MCU (master) and the command receiver (slave).
interface spi_cmd_rx_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver: 16-bit frames {opcode, data} configure the wavegen.
// Define SPI_READBACK_EN to shift the status word {selector, freq_step} out on miso.
module spi_cmd_rx (
    input  logic               clk,
    input  logic               rst,
    spi_cmd_rx_if.slave        spi,
    output logic [3:0]         selector,
    output logic [11:0]        freq_step,
    output logic               run,
    output logic               cfg_strobe,
    output logic               frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  sclk_sync;
    logic [2:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic [15:0] shift_q;
    logic [4:0]  bit_cnt;
    logic        start_frame;
    logic        shift_en;
    logic        bad_len;
    logic        commit;

    // Synchronizers reset low so a cs_n already low at reset release is not
    // seen as a falling edge; the host must raise and drop it again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi.sclk};
            cs_sync   <= {cs_sync[1:0], spi.cs_n};
            mosi_sync <= {mosi_sync[0], spi.mosi};
        end
    end

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        bad_len     = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt == 5'd16) begin
                        next_state = COMMIT;
                    end else begin
                        next_state = IDLE;
                        bad_len    = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame capture and the configuration registers; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= 16'h0000;
            bit_cnt    <= 5'd0;
            selector   <= 4'b0100;
            freq_step  <= 12'd1;
            run        <= 1'b0;
            cfg_strobe <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_strobe <= 1'b0;
            frame_err  <= bad_len;
            if (start_frame) begin
                shift_q <= 16'h0000;
                bit_cnt <= 5'd0;
            end else if (shift_en) begin
                shift_q <= {shift_q[14:0], mosi_sync[1]};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (commit) begin
                case (shift_q[15:12])
                    4'h0: cfg_strobe <= 1'b1;
                    4'h1: begin
                        selector   <= shift_q[3:0];
                        cfg_strobe <= 1'b1;
                    end
                    4'h2: begin
                        freq_step  <= shift_q[11:0];
                        cfg_strobe <= 1'b1;
                    end
                    4'h3: begin
                        run        <= shift_q[0];
                        cfg_strobe <= 1'b1;
                    end
                    default: frame_err <= 1'b1;
                endcase
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic [15:0] status_q;
    logic        miso_q;
    logic        sclk_fall;
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];

    // Status is snapshotted at frame start so the host reads the pre-frame config.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 16'h0000;
            miso_q   <= 1'b0;
        end else if (cs_sync[1]) begin
            miso_q   <= 1'b0;
        end else if (start_frame) begin
            status_q <= {selector, freq_step};
            miso_q   <= selector[3];
        end else if (state == SHIFT && sclk_fall) begin
            status_q <= {status_q[14:0], 1'b0};
            miso_q   <= status_q[14];
        end
    end
    assign spi.miso = miso_q;
`else
    assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: frames are driven bit by bit, expected outcomes
// are queued by a small command model and checked once each frame settles.
module tb_spi_cmd_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  selector;
    logic [11:0] freq_step;
    logic        run;
    logic        cfg_strobe;
    logic        frame_err;

    spi_cmd_rx_if bus ();

    spi_cmd_rx dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (bus),
        .selector   (selector),
        .freq_step  (freq_step),
        .run        (run),
        .cfg_strobe (cfg_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          strobes;
        int          errs;
        logic [3:0]  sel;
        logic [11:0] freq;
        logic        run;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          strobe_cnt = 0;
    int          err_cnt    = 0;
    int          both_cnt   = 0;
    logic [3:0]  m_sel;
    logic [11:0] m_freq;
    logic        m_run;
    logic [15:0] rb;

    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_strobe) strobe_cnt++;
            if (frame_err) err_cnt++;
            if (cfg_strobe && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sel  = 4'b0100;
        m_freq = 12'd1;
        m_run  = 1'b0;
    endtask

    task automatic push_expect(input int add_strobes, input int add_errs);
        exp_t e;
        e.strobes = strobe_cnt + add_strobes;
        e.errs    = err_cnt + add_errs;
        e.sel     = m_sel;
        e.freq    = m_freq;
        e.run     = m_run;
        sb.push_back(e);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        clocks(5);
        rst = 1'b0;
        model_reset();
        clocks(5);
    endtask

    // Mode 0: mosi changes while sclk is low; miso is sampled just before each rise.
    task automatic drive_bits(input logic [31:0] val, input int nbits, output logic [15:0] rdata);
        logic [31:0] v;
        v = val;
        rdata = 16'h0000;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.mosi = v[i];
            clocks(4);
            rdata = {rdata[14:0], bus.miso};
            bus.sclk = 1'b1;
            clocks(4);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] val, input int nbits, output logic [15:0] rdata);
        logic [15:0] f;
        f = val[15:0];
        if (nbits != 16) begin
            push_expect(0, 1);
        end else begin
            case (f[15:12])
                4'h0: push_expect(1, 0);
                4'h1: begin m_sel  = f[3:0];  push_expect(1, 0); end
                4'h2: begin m_freq = f[11:0]; push_expect(1, 0); end
                4'h3: begin m_run  = f[0];    push_expect(1, 0); end
                default: push_expect(0, 1);
            endcase
        end
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        clocks(6);
        drive_bits(val, nbits, rdata);
        clocks(4);
        @(posedge clk);
        #1 bus.cs_n = 1'b1;
    endtask

    task automatic check_output();
        exp_t e;
        clocks(10);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("strobe_count", strobe_cnt, e.strobes);
            check("err_count", err_cnt, e.errs);
            check("selector", {28'd0, selector}, {28'd0, e.sel});
            check("freq_step", {20'd0, freq_step}, {20'd0, e.freq});
            check("run", {31'd0, run}, {31'd0, e.run});
            check("no_overlap", both_cnt, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst      = 1'b1;
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        model_reset();
        clocks(5);
        check("rst_selector", {28'd0, selector}, 32'h4);
        check("rst_freq", {20'd0, freq_step}, 32'h1);
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_strobe", {31'd0, cfg_strobe}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_miso", {31'd0, bus.miso}, 32'd0);
        rst = 1'b0;
        clocks(5);

        $display("[TB] frame 0x1003 with commit latency");
        apply_stimulus(32'h1003, 16, rb);
        clocks(3);
        check("lat_edge3_strobe", {31'd0, cfg_strobe}, 32'd0);
        check("lat_edge3_sel", {28'd0, selector}, 32'h4);
        clocks(1);
        check("lat_edge4_strobe", {31'd0, cfg_strobe}, 32'd1);
        check("lat_edge4_sel", {28'd0, selector}, 32'h3);
        check_output();

        $display("[TB] frames 0x2ABC then 0x3001 from reset");
        do_reset();
        apply_stimulus(32'h2ABC, 16, rb);
        check_output();
`ifndef SPI_READBACK_EN
        check("miso_tied_low", {16'd0, rb}, 32'd0);
`endif
        apply_stimulus(32'h3001, 16, rb);
        check_output();

        $display("[TB] short and long frames");
        apply_stimulus(32'h1005 >> 1, 15, rb);
        check_output();
        apply_stimulus(32'h1_0005, 17, rb);
        check_output();

        $display("[TB] illegal opcode 0x7123");
        apply_stimulus(32'h7123, 16, rb);
        check_output();

        $display("[TB] sclk toggles while deselected");
        push_expect(0, 0);
        drive_bits(32'h1009, 16, rb);
        check_output();

        $display("[TB] reset mid-frame on 0x2FFF");
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        clocks(6);
        drive_bits(32'h2F, 8, rb);
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        model_reset();
        drive_bits(32'hFF, 8, rb);
        clocks(4);
        bus.cs_n = 1'b1;
        push_expect(0, 0);
        check_output();
        apply_stimulus(32'h3001, 16, rb);
        check_output();

        $display("[TB] zero-bit frame");
        push_expect(0, 1);
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        @(posedge clk);
        #1 bus.cs_n = 1'b1;
        check_output();

`ifdef SPI_READBACK_EN
        $display("[TB] readback of status word");
        apply_stimulus(32'h1005, 16, rb);
        check_output();
        apply_stimulus(32'h2123, 16, rb);
        check_output();
        apply_stimulus(32'h0000, 16, rb);
        check("readback_word", {16'd0, rb}, 32'h5123);
        check_output();
        check("miso_deselected", {31'd0, bus.miso}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
